if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode/controller stage.
- Holds the PC and drives the instruction-memory address.
- Owns the IF/ID pipeline register.
- Honours stall requests from the hazard unit and redirects/flushes on branch, jump, jal and jr resolved in ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- pc_write  input  1  1 = PC may update; 0 = hold (hazard stall)
- if_id_write  input  1  1 = IF/ID may load; 0 = hold
- pcsrc  input  1  1 = redirect requested by the instruction in ID
- ex_mem_sel  input  2  redirect kind: 00 branch, 10 jump/jal, 01 jr, 11 reserved
- jr_target  input  32  register-file value for jr
- imem_addr  output  32  byte address to instruction memory (= pc)
- imem_rdata  input  32  instruction at imem_addr; combinational, same-cycle read
- pc  output  32  current PC
- if_id_instr  output  32  registered instruction
- if_id_pc4  output  32  registered PC+4 of that instruction (jal link value, branch base)
- if_id_valid  output  1  1 = if_id_instr is a real fetched instruction

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at posedge): pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0. Reset overrides all other inputs, including mid-stall or mid-redirect.
- pc_seq = pc + PC_STEP, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Branch target: if_id_pc4 + ({{14{if_id_instr[15]}}, if_id_instr[15:0], 2'b00}), 32-bit wrap.
- Jump target: {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}.
- Jr target: jr_target.
- redirect = pcsrc & if_id_valid & (ex_mem_sel != 11). A bubble never redirects; reserved code 11 means no redirect.
- PC update at posedge, when pc_write=1:
  - pc <= selected target if redirect.
  - otherwise pc <= pc_seq.
- PC hold: when pc_write=0, pc holds.
- IF/ID update at posedge, priority order:
  1. pc_write=1 & redirect: flush. if_id_instr<=0, if_id_pc4<=0, if_id_valid<=0. Exactly one bubble per taken redirect.
  2. if_id_write=1 & !redirect: load. if_id_instr<=imem_rdata, if_id_pc4<=pc_seq, if_id_valid<=1.
  3. Otherwise: hold all three.
- Stall vs redirect: if pc_write=0, redirect is ignored for that cycle (the ID instruction is stalled and re-evaluated). No PC change, no flush.
- pc_write and if_id_write are independent. pc_write=0 with if_id_write=1 reloads IF/ID with the same imem_rdata.
- imem_addr is combinational from the pc register. Latency: instruction visible on if_id_instr one cycle after its PC appears on imem_addr.
- All-zero instruction is the bubble encoding; decode treats it as a harmless R-type with rd=0.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds outputs stall_cnt[31:0] and flush_cnt[31:0], both cleared by rst.
  - stall_cnt increments each cycle pc_write=0.
  - flush_cnt increments each cycle a flush occurs.
  - Both wrap at 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then 4 cycles, pc_write=if_id_write=1, pcsrc=0 -> pc 0,4,8,C; if_id_pc4 4,8,C; if_id_valid rises one cycle after reset release.
- pc=0x10, pc_write=if_id_write=0 for 2 cycles -> pc stays 0x10, IF/ID holds; resumes to 0x14 after release.
- IF/ID holds beq at pc4=0x20, imm=0xFFFE, pcsrc=1, ex_mem_sel=00 -> pc becomes 0x18; next cycle if_id_valid=0, if_id_instr=0.
- IF/ID holds j with target 0x000040 at pc4=0x4000_0008, ex_mem_sel=10 -> pc=0x4000_0100. Separately, jr with jr_target=0x0000_0200, ex_mem_sel=01 -> pc=0x200.
- pcsrc=1 with pc_write=0 -> no redirect, no flush. pcsrc=1 with if_id_valid=0 or ex_mem_sel=11 -> sequential fetch.
- pc=0xFFFF_FFFC, no redirect -> pc=0. rst asserted during a stall -> pc=RESET_PC, if_id_valid=0 next cycle.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch redirect/stall control and the IF/ID register.
// Optional stall/flush counters are compiled in when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        pcsrc,
  input  logic [1:0]  ex_mem_sel,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [1:0] SEL_BRANCH = 2'b00;
  localparam logic [1:0] SEL_JR     = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_RSVD   = 2'b11;

  function automatic logic [31:0] branch_target(input logic [31:0] base, input logic [15:0] imm);
    logic signed [31:0] offset;
    offset = {{14{imm[15]}}, imm, 2'b00};
    return base + unsigned'(offset);
  endfunction

  function automatic logic [31:0] jump_target(input logic [3:0] region, input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

  logic [31:0] pc_p0;
  logic [31:0] instr_p1;
  logic [31:0] pc4_p1;
  logic        vld_p1;
  logic [31:0] pc_seq;
  logic [31:0] pc_next;
  logic        redirect;
  logic        flush;

  assign pc_seq   = pc_p0 + 32'(PC_STEP);
  assign redirect = pcsrc & vld_p1 & (ex_mem_sel != SEL_RSVD);
  assign flush    = pc_write & redirect;

  always_comb begin
    pc_next = pc_seq;
    if (redirect) begin
      case (ex_mem_sel)
        SEL_BRANCH: pc_next = branch_target(pc4_p1, instr_p1[15:0]);
        SEL_JUMP:   pc_next = jump_target(pc4_p1[31:28], instr_p1[25:0]);
        SEL_JR:     pc_next = jr_target;
        default:    pc_next = pc_seq;
      endcase
    end
  end

  // Stage boundary: PC (p0) and IF/ID register (p1); a stalled PC ignores redirects
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0    <= RESET_PC;
      instr_p1 <= '0;
      pc4_p1   <= '0;
      vld_p1   <= 1'b0;
    end else begin
      if (pc_write) pc_p0 <= pc_next;
      if (flush) begin
        instr_p1 <= '0;
        pc4_p1   <= '0;
        vld_p1   <= 1'b0;
      end else if (if_id_write && !redirect) begin
        instr_p1 <= imem_rdata;
        pc4_p1   <= pc_seq;
        vld_p1   <= 1'b1;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write) stall_cnt <= stall_cnt + 32'd1;
      if (flush)     flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

  assign pc          = pc_p0;
  assign imem_addr   = pc_p0;
  assign if_id_instr = instr_p1;
  assign if_id_pc4   = pc4_p1;
  assign if_id_valid = vld_p1;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stalls, branch/jump/jr redirects, wrap and reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic        if_id_write;
  logic        pcsrc;
  logic [1:0]  ex_mem_sel;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  logic        use_ovr;
  logic [31:0] ovr_instr;
  int          tests = 0;
  int          failed = 0;

  // Memory model: address tagged with a constant unless an explicit instruction is forced.
  assign imem_rdata = use_ovr ? ovr_instr : (imem_addr ^ 32'hDEAD_0000);

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_write(if_id_write),
    .pcsrc(pcsrc), .ex_mem_sel(ex_mem_sel), .jr_target(jr_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
`ifdef IF_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_write = 1'b1; if_id_write = 1'b1; pcsrc = 1'b1;
    ex_mem_sel = 2'b01; jr_target = 32'h1234_5678; use_ovr = 1'b0; ovr_instr = '0;
    step(); step();
    tests++; if (pc !== 32'h0) begin failed++; $display("FAIL reset_pc: got %h exp %h", pc, 32'h0); end
    tests++; if (imem_addr !== 32'h0) begin failed++; $display("FAIL reset_addr: got %h exp %h", imem_addr, 32'h0); end
    tests++; if (if_id_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b exp 0", if_id_valid); end
    tests++; if (if_id_instr !== 32'h0) begin failed++; $display("FAIL reset_instr: got %h exp 0", if_id_instr); end
    tests++; if (if_id_pc4 !== 32'h0) begin failed++; $display("FAIL reset_pc4: got %h exp 0", if_id_pc4); end
`ifdef IF_PERF_CNT_EN
    tests++; if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0) begin
      failed++; $display("FAIL reset_cnt: got %h/%h exp 0/0", stall_cnt, flush_cnt); end
`endif
  endtask

  task automatic test_sequential();
    rst = 1'b0; pcsrc = 1'b0; ex_mem_sel = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      step();
      tests++; if (pc !== 32'(4 * i)) begin failed++; $display("FAIL seq_pc[%0d]: got %h exp %h", i, pc, 32'(4 * i)); end
      tests++; if (if_id_pc4 !== 32'(4 * i)) begin failed++; $display("FAIL seq_pc4[%0d]: got %h exp %h", i, if_id_pc4, 32'(4 * i)); end
      tests++; if (if_id_instr !== (32'(4 * (i - 1)) ^ 32'hDEAD_0000)) begin
        failed++; $display("FAIL seq_instr[%0d]: got %h exp %h", i, if_id_instr, 32'(4 * (i - 1)) ^ 32'hDEAD_0000); end
      tests++; if (if_id_valid !== 1'b1) begin failed++; $display("FAIL seq_valid[%0d]: got %b exp 1", i, if_id_valid); end
    end
  endtask

  task automatic test_stall();
    pc_write = 1'b0; if_id_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++; if (pc !== 32'h10) begin failed++; $display("FAIL stall_pc[%0d]: got %h exp 10", i, pc); end
      tests++; if (if_id_pc4 !== 32'h10 || if_id_instr !== 32'hDEAD_000C) begin
        failed++; $display("FAIL stall_ifid[%0d]: got %h/%h exp 10/dead000c", i, if_id_pc4, if_id_instr); end
    end
    pc_write = 1'b1; if_id_write = 1'b1;
    step();
    tests++; if (pc !== 32'h14) begin failed++; $display("FAIL stall_resume_pc: got %h exp 14", pc); end
    tests++; if (if_id_instr !== 32'hDEAD_0010) begin failed++; $display("FAIL stall_resume_instr: got %h exp dead0010", if_id_instr); end
  endtask

  task automatic test_branch();
    step(); step();
    tests++; if (pc !== 32'h1C) begin failed++; $display("FAIL br_setup_pc: got %h exp 1c", pc); end
    use_ovr = 1'b1; ovr_instr = 32'h1000_FFFE;
    step();
    tests++; if (if_id_pc4 !== 32'h20 || if_id_instr !== 32'h1000_FFFE) begin
      failed++; $display("FAIL br_load: got %h/%h exp 20/1000fffe", if_id_pc4, if_id_instr); end
    pcsrc = 1'b1; ex_mem_sel = 2'b00;
    step();
    tests++; if (pc !== 32'h18) begin failed++; $display("FAIL br_target: got %h exp 18", pc); end
    tests++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin
      failed++; $display("FAIL br_flush: got v=%b %h/%h exp v=0 0/0", if_id_valid, if_id_instr, if_id_pc4); end
    step();
    tests++; if (pc !== 32'h1C || if_id_valid !== 1'b1) begin
      failed++; $display("FAIL bubble_no_redirect: got pc=%h v=%b exp pc=1c v=1", pc, if_id_valid); end
    ex_mem_sel = 2'b11;
    step();
    tests++; if (pc !== 32'h20 || if_id_valid !== 1'b1 || if_id_pc4 !== 32'h20) begin
      failed++; $display("FAIL rsvd_no_redirect: got pc=%h v=%b pc4=%h exp 20/1/20", pc, if_id_valid, if_id_pc4); end
    ex_mem_sel = 2'b00; pc_write = 1'b0; if_id_write = 1'b0;
    step();
    tests++; if (pc !== 32'h20 || if_id_valid !== 1'b1 || if_id_instr !== 32'h1000_FFFE) begin
      failed++; $display("FAIL stall_blocks_redirect: got pc=%h v=%b i=%h exp 20/1/1000fffe", pc, if_id_valid, if_id_instr); end
    pc_write = 1'b1; if_id_write = 1'b1;
  endtask

  task automatic test_jump();
    pcsrc = 1'b1; ex_mem_sel = 2'b01; jr_target = 32'h4000_0004;
    step();
    tests++; if (pc !== 32'h4000_0004 || if_id_valid !== 1'b0) begin
      failed++; $display("FAIL jr_setup: got pc=%h v=%b exp 40000004/0", pc, if_id_valid); end
    pcsrc = 1'b0; ovr_instr = 32'h0800_0040;
    step();
    tests++; if (if_id_pc4 !== 32'h4000_0008 || if_id_instr !== 32'h0800_0040) begin
      failed++; $display("FAIL j_load: got %h/%h exp 40000008/08000040", if_id_pc4, if_id_instr); end
    pcsrc = 1'b1; ex_mem_sel = 2'b10;
    step();
    tests++; if (pc !== 32'h4000_0100) begin failed++; $display("FAIL j_target: got %h exp 40000100", pc); end
    tests++; if (if_id_valid !== 1'b0) begin failed++; $display("FAIL j_flush: got %b exp 0", if_id_valid); end
    pcsrc = 1'b0;
    step();
    pcsrc = 1'b1; ex_mem_sel = 2'b01; jr_target = 32'h0000_0200;
    step();
    tests++; if (pc !== 32'h200) begin failed++; $display("FAIL jr_target: got %h exp 200", pc); end
  endtask

  task automatic test_wrap();
    pcsrc = 1'b0;
    step();
    pcsrc = 1'b1; ex_mem_sel = 2'b01; jr_target = 32'hFFFF_FFFC;
    step();
    tests++; if (pc !== 32'hFFFF_FFFC) begin failed++; $display("FAIL wrap_setup: got %h exp fffffffc", pc); end
    pcsrc = 1'b0;
    step();
    tests++; if (pc !== 32'h0) begin failed++; $display("FAIL wrap_pc: got %h exp 0", pc); end
    tests++; if (if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1) begin
      failed++; $display("FAIL wrap_pc4: got %h v=%b exp 0 v=1", if_id_pc4, if_id_valid); end
  endtask

  task automatic test_reset_in_stall();
    step();
    tests++; if (pc !== 32'h4) begin failed++; $display("FAIL rst_stall_setup: got %h exp 4", pc); end
    pc_write = 1'b0; if_id_write = 1'b0; pcsrc = 1'b1; ex_mem_sel = 2'b01; rst = 1'b1;
    step();
    tests++; if (pc !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
      failed++; $display("FAIL rst_stall: got pc=%h v=%b i=%h exp 0/0/0", pc, if_id_valid, if_id_instr); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump();
    test_wrap();
    test_reset_in_stall();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
